// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: single-entry instruction/data latches in front of a one-access-at-a-time backing memory; CPU fetch port (instruction_*), CPU load/store port (data_request, write_enable, mem_*, write_data), backing port (pmem_*)
module cpu_mem_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        instruction_request,
  input  logic [15:0] instruction_address,
  output logic [15:0] instr,
  output logic        instruction_response,
  input  logic        data_request,
  input  logic        write_enable,
  input  logic [15:0] mem_address,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] write_data,
  output logic [15:0] mem_rdata,
  output logic        data_response,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_byte_enable,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp
);
  typedef enum logic [1:0] {IDLE, IFETCH, DACCESS} state_t;
  state_t state, state_n;
  logic i_valid, d_valid, d_we;
  logic [15:0] i_addr, i_data, d_addr, d_wdata, d_data;
  logic [1:0] d_be;
  logic i_hit, d_hit, start_d, start_i, done;
  assign i_hit = i_valid & instruction_request & (instruction_address == i_addr);
  // stores only hit when every field matches, so a repeated identical store is idempotent
  assign d_hit = d_valid & data_request & (mem_address == d_addr) & (write_enable == d_we) &
                 (!write_enable | ((mem_byte_enable == d_be) & (write_data == d_wdata)));
  assign instruction_response = i_hit;
  assign data_response = d_hit;
  assign instr = i_data;
  assign mem_rdata = d_data;
  always_comb begin
    start_d = (state == IDLE) & data_request & !d_hit;
    start_i = (state == IDLE) & !start_d & instruction_request & !i_hit;
    done = (state != IDLE) & pmem_resp;
    state_n = start_d ? DACCESS : start_i ? IFETCH : done ? IDLE : state;
  end
  // the pmem_* registers double as the captured request, so CPU input changes cannot disturb an access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pmem_read <= 1'b0;
      pmem_write <= 1'b0;
      pmem_address <= '0;
      pmem_wdata <= '0;
      pmem_byte_enable <= '0;
      i_valid <= 1'b0;
      i_addr <= '0;
      i_data <= '0;
      d_valid <= 1'b0;
      d_addr <= '0;
      d_we <= 1'b0;
      d_be <= '0;
      d_wdata <= '0;
      d_data <= '0;
    end else begin
      state <= state_n;
      if (start_d | start_i) begin
        pmem_read <= start_i | !write_enable;
        pmem_write <= start_d & write_enable;
        pmem_address <= start_d ? mem_address : instruction_address;
        pmem_wdata <= start_d ? write_data : '0;
        pmem_byte_enable <= start_d ? mem_byte_enable : '0;
      end else if (done) begin
        pmem_read <= 1'b0;
        pmem_write <= 1'b0;
      end
      if (done & (state == IFETCH)) begin
        i_valid <= 1'b1;
        i_addr <= pmem_address;
        i_data <= pmem_rdata;
      end
      if (done & (state == DACCESS)) begin
        d_valid <= 1'b1;
        d_addr <= pmem_address;
        d_we <= pmem_write;
        d_be <= pmem_byte_enable;
        d_wdata <= pmem_wdata;
        d_data <= pmem_write ? pmem_wdata : pmem_rdata;
        // a store into the word holding the latched instruction makes that instruction stale
        if (pmem_write & (i_addr[15:1] == pmem_address[15:1])) i_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed and random checks of cpu_mem_responder against a backing-memory model and a request-level hit model
module tb_cpu_mem_responder;
  logic clk = 1'b0;
  logic reset;
  logic instruction_request, data_request, write_enable;
  logic [15:0] instruction_address, mem_address, write_data;
  logic [1:0] mem_byte_enable;
  logic [15:0] instr, mem_rdata, pmem_address, pmem_wdata;
  logic instruction_response, data_response, pmem_read, pmem_write;
  logic [1:0] pmem_byte_enable;
  logic [15:0] pmem_rdata = '0;
  logic pmem_resp = 1'b0;
  int errors = 0;
  int checks = 0;
  int fixed_lat = 2;
  int stray_req = 0;
  logic [15:0] mem [0:511];
  logic [16:0] acc_q [$];
  int base;
  logic ir, dr, we_r, dmiss, imiss;
  logic [15:0] ia, da, wd;
  logic [1:0] be;
  logic m_iv, m_dv, m_dwe;
  logic [15:0] m_ia, m_da, m_dwd;
  logic [1:0] m_dbe;

  cpu_mem_responder dut (
    .clk(clk), .reset(reset),
    .instruction_request(instruction_request), .instruction_address(instruction_address),
    .instr(instr), .instruction_response(instruction_response),
    .data_request(data_request), .write_enable(write_enable), .mem_address(mem_address),
    .mem_byte_enable(mem_byte_enable), .write_data(write_data),
    .mem_rdata(mem_rdata), .data_response(data_response),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] acc_at(input int i);
    return (i < acc_q.size()) ? 32'(acc_q[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic wait_resp(input logic wi, input logic wdr, input int budget);
    logic ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk); #1;
      ok = (!wi || instruction_response) && (!wdr || data_response);
    end
    chk("resp_within_budget", 32'(ok), 32'd1);
  endtask

  task automatic wait_read(input int budget);
    logic ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk); #1;
      ok = pmem_read;
    end
    chk("pmem_read_within_budget", 32'(ok), 32'd1);
  endtask

  // backing memory: word array, byte-lane stores, configurable or random latency
  initial begin
    int wait_cnt;
    int stray_seen;
    logic busy;
    logic [15:0] baddr, w;
    wait_cnt = 0;
    stray_seen = 0;
    busy = 1'b0;
    baddr = '0;
    for (int i = 0; i < 512; i++) mem[i] = 16'(i * 16'h0203) ^ 16'h5A5A;
    mem[8] = 16'h1234;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (stray_seen != stray_req) begin
        stray_seen = stray_req;
        pmem_rdata = 16'hDEAD;
        pmem_resp = 1'b1;
      end else if (!reset && (pmem_read || pmem_write)) begin
        if (!busy) begin
          busy = 1'b1;
          baddr = pmem_address;
          wait_cnt = (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
        end else chk("pmem_addr_stable", 32'(pmem_address), 32'(baddr));
        if (wait_cnt == 0) begin
          if (pmem_write) begin
            w = mem[pmem_address[9:1]];
            if (pmem_byte_enable[1]) w[15:8] = pmem_wdata[15:8];
            if (pmem_byte_enable[0]) w[7:0] = pmem_wdata[7:0];
            mem[pmem_address[9:1]] = w;
          end else pmem_rdata = mem[pmem_address[9:1]];
          acc_q.push_back({pmem_write, pmem_address});
          pmem_resp = 1'b1;
          busy = 1'b0;
        end else wait_cnt--;
      end else busy = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    instruction_request = 1'b0; instruction_address = '0;
    data_request = 1'b0; write_enable = 1'b0; mem_address = '0;
    mem_byte_enable = '0; write_data = '0;
    @(negedge clk); #1;
    chk("rst_iresp", 32'(instruction_response), 0);
    chk("rst_dresp", 32'(data_response), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_rdata", 32'(mem_rdata), 0);
    chk("rst_pread", 32'(pmem_read), 0);
    chk("rst_pwrite", 32'(pmem_write), 0);
    chk("rst_paddr", 32'(pmem_address), 0);
    chk("rst_pwdata", 32'(pmem_wdata), 0);
    chk("rst_pbe", 32'(pmem_byte_enable), 0);
    @(negedge clk);
    reset = 1'b0;
    // fetch, hold, and same-cycle drop on address change
    @(negedge clk);
    fixed_lat = 2;
    instruction_request = 1'b1; instruction_address = 16'h0010;
    wait_resp(1'b1, 1'b0, 20);
    chk("fetch_instr", 32'(instr), 32'h1234);
    repeat (3) begin
      @(negedge clk); #1;
      chk("fetch_hold_resp", 32'(instruction_response), 1);
      chk("fetch_hold_noread", 32'(pmem_read), 0);
    end
    @(negedge clk);
    instruction_address = 16'h0012; #1;
    chk("fetch_drop", 32'(instruction_response), 0);
    instruction_request = 1'b0;
    // simultaneous fetch and load: load issued first
    @(negedge clk);
    base = acc_q.size();
    instruction_request = 1'b1; instruction_address = 16'h0020;
    data_request = 1'b1; write_enable = 1'b0; mem_address = 16'h0100;
    wait_resp(1'b1, 1'b1, 30);
    chk("both_count", 32'(acc_q.size() - base), 2);
    chk("both_first_load", acc_at(base), 32'h0_0100);
    chk("both_second_fetch", acc_at(base + 1), 32'h0_0020);
    chk("both_instr", 32'(instr), 32'(mem[16]));
    chk("both_rdata", 32'(mem_rdata), 32'(mem[128]));
    // store coherence
    @(negedge clk);
    data_request = 1'b0; instruction_address = 16'h0040;
    wait_resp(1'b1, 1'b0, 20);
    @(negedge clk);
    instruction_request = 1'b0;
    base = acc_q.size();
    data_request = 1'b1; write_enable = 1'b1; mem_address = 16'h0041;
    mem_byte_enable = 2'b11; write_data = 16'hBEEF;
    wait_resp(1'b0, 1'b1, 20);
    chk("store_access", acc_at(base), 32'h1_0041);
    chk("store_rdata", 32'(mem_rdata), 32'hBEEF);
    @(negedge clk);
    data_request = 1'b0;
    instruction_request = 1'b1; #1;
    chk("coherence_invalid", 32'(instruction_response), 0);
    wait_resp(1'b1, 1'b0, 20);
    chk("refetch_access", acc_at(base + 1), 32'h0_0040);
    chk("refetch_instr", 32'(instr), 32'hBEEF);
    // mid-access change of the load address
    @(negedge clk);
    instruction_request = 1'b0;
    fixed_lat = 3;
    base = acc_q.size();
    data_request = 1'b1; write_enable = 1'b0; mem_address = 16'h0200;
    wait_read(10);
    mem_address = 16'h0202;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk); #1;
      chk("midchg_dresp_low", 32'(data_response), 0);
      if (!pmem_read) break;
      chk("midchg_paddr", 32'(pmem_address), 32'h0200);
    end
    wait_resp(1'b0, 1'b1, 20);
    chk("midchg_first", acc_at(base), 32'h0_0200);
    chk("midchg_second", acc_at(base + 1), 32'h0_0202);
    chk("midchg_rdata", 32'(mem_rdata), 32'(mem[257]));
    // reset mid-access and stray response
    @(negedge clk);
    data_request = 1'b0;
    fixed_lat = 5;
    instruction_request = 1'b1; instruction_address = 16'h0030;
    wait_read(10);
    reset = 1'b1; #1;
    chk("rstmid_pread", 32'(pmem_read), 0);
    chk("rstmid_paddr", 32'(pmem_address), 0);
    chk("rstmid_instr", 32'(instr), 0);
    chk("rstmid_rdata", 32'(mem_rdata), 0);
    chk("rstmid_iresp", 32'(instruction_response), 0);
    instruction_request = 1'b0;
    stray_req++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    instruction_request = 1'b1; instruction_address = 16'h0030;
    data_request = 1'b1; write_enable = 1'b0; mem_address = 16'h0202; #1;
    chk("stray_iresp", 32'(instruction_response), 0);
    chk("stray_dresp", 32'(data_response), 0);
    chk("stray_instr", 32'(instr), 0);
    chk("stray_pread", 32'(pmem_read), 0);
    instruction_request = 1'b0; data_request = 1'b0;
    // stall hold
    @(negedge clk);
    fixed_lat = 1;
    data_request = 1'b1; mem_address = 16'h0004;
    wait_resp(1'b0, 1'b1, 20);
    repeat (5) begin
      @(negedge clk); #1;
      chk("stall_dresp", 32'(data_response), 1);
      chk("stall_noread", 32'(pmem_read), 0);
    end
    // random traffic against the hit model
    @(negedge clk);
    data_request = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fixed_lat = -1;
    m_iv = 1'b0; m_dv = 1'b0; m_dwe = 1'b0;
    m_ia = '0; m_da = '0; m_dwd = '0; m_dbe = '0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (!ir && !dr) ir = 1'b1;
      we_r = 1'($urandom_range(0, 1));
      ia = 16'($urandom_range(0, 15) * 2);
      da = 16'($urandom_range(0, 31));
      be = 2'($urandom_range(1, 3));
      wd = $urandom_range(0, 1) ? 16'hA0A0 : 16'h5B5B;
      dmiss = dr && !(m_dv && m_da == da && m_dwe == we_r && (!we_r || (m_dbe == be && m_dwd == wd)));
      if (dmiss && we_r && m_ia[15:1] == da[15:1]) m_iv = 1'b0;
      imiss = ir && !(m_iv && m_ia == ia);
      base = acc_q.size();
      instruction_request = ir; instruction_address = ia;
      data_request = dr; write_enable = we_r; mem_address = da;
      mem_byte_enable = be; write_data = wd;
      wait_resp(ir, dr, 40);
      chk("rnd_acc_count", 32'(acc_q.size() - base), 32'(int'(dmiss) + int'(imiss)));
      if (dmiss) chk("rnd_data_first", acc_at(base), 32'({we_r, da}));
      if (ir) chk("rnd_instr", 32'(instr), 32'(mem[ia[9:1]]));
      if (dr) chk("rnd_rdata", 32'(mem_rdata), 32'(we_r ? wd : mem[da[9:1]]));
      repeat (2) begin
        @(negedge clk); #1;
        chk("rnd_hold_resp", 32'({instruction_response, data_response}), 32'({ir, dr}));
        chk("rnd_hold_idle", 32'(pmem_read | pmem_write), 0);
      end
      if (dr) begin
        m_dv = 1'b1; m_dwe = we_r; m_da = da; m_dbe = be; m_dwd = wd;
      end
      if (ir) begin
        m_iv = 1'b1; m_ia = ia;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
